// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the rggen register slices: access bit positions,
// response status codes, the slice FSM state type and a constant log2 helper.
package rggen_rtl_pkg;

    localparam int ACCESS_WRITE_BIT      = 0;
    localparam int ACCESS_NON_POSTED_BIT = 1;

    localparam logic [1:0] STATUS_OKAY        = 2'b00;
    localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;

    typedef enum logic {
        STATE_IDLE,
        STATE_RESP
    } state_e;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rggen_wide_register_decoder.sv
// Combinational byte-address decode into {active, entry, beat} for a register
// array whose entries each span BEATS bus words.
module rggen_wide_register_decoder
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int OFFSET_ADDRESS = 0,
    parameter int BUS_WIDTH      = 32,
    parameter int BEATS          = 2,
    parameter int ARRAY_SIZE     = 4,
    parameter int ENTRY_WIDTH    = 2,
    parameter int BEAT_WIDTH     = 1
)(
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic                     active,
    output logic [ENTRY_WIDTH-1:0]   entry,
    output logic [BEAT_WIDTH-1:0]    beat
);

    localparam int BYTE_SHIFT = clog2(BUS_WIDTH / 8);
    localparam int BEAT_SHIFT = clog2(BEATS);
    localparam logic [ADDRESS_WIDTH-1:0] BASE        = ADDRESS_WIDTH'(OFFSET_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] ENTRY_LIMIT = ADDRESS_WIDTH'(ARRAY_SIZE);
    localparam logic [ADDRESS_WIDTH-1:0] BEAT_MASK   = ADDRESS_WIDTH'(BEATS - 1);

    logic [ADDRESS_WIDTH-1:0] word_index;
    logic [ADDRESS_WIDTH-1:0] entry_index;

    always_comb begin
        word_index  = (address - BASE) >> BYTE_SHIFT;
        entry_index = word_index >> BEAT_SHIFT;
        active      = (address >= BASE) && (entry_index < ENTRY_LIMIT);
        entry       = ENTRY_WIDTH'(entry_index);
        beat        = BEAT_WIDTH'(word_index & BEAT_MASK);
    end

endmodule

// File: rtl/rggen_wide_register_array.sv
// Register-array slice for registers wider than the bus: writes stage and commit
// atomically on the last beat. RGGEN_WIDE_REGISTER_SNAPSHOT_EN enables the read snapshot.
module rggen_wide_register_array
    import rggen_rtl_pkg::*;
#(
    parameter bit READABLE       = 1'b1,
    parameter bit WRITABLE       = 1'b1,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int OFFSET_ADDRESS = 0,
    parameter int BUS_WIDTH      = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ARRAY_SIZE     = 4
)(
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_register_valid,
    input  logic [1:0]                       i_register_access,
    input  logic [ADDRESS_WIDTH-1:0]         i_register_address,
    input  logic [BUS_WIDTH-1:0]             i_register_write_data,
    input  logic [BUS_WIDTH/8-1:0]           i_register_strobe,
    output logic                             o_register_active,
    output logic                             o_register_ready,
    output logic [1:0]                       o_register_status,
    output logic [BUS_WIDTH-1:0]             o_register_read_data,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_register_value,
    output logic [ARRAY_SIZE-1:0]            o_bit_field_valid,
    output logic [DATA_WIDTH-1:0]            o_bit_field_read_mask,
    output logic [DATA_WIDTH-1:0]            o_bit_field_write_mask,
    output logic [DATA_WIDTH-1:0]            o_bit_field_write_data,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_bit_field_read_data,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_bit_field_value
);

    localparam int BEATS       = DATA_WIDTH / BUS_WIDTH;
    localparam int BYTES       = BUS_WIDTH / 8;
    localparam int ENTRY_WIDTH = (ARRAY_SIZE > 1) ? clog2(ARRAY_SIZE) : 1;
    localparam int BEAT_WIDTH  = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

    logic                   active;
    logic [ENTRY_WIDTH-1:0] entry;
    logic [BEAT_WIDTH-1:0]  beat;
    logic                   accept;
    state_e                 state, next_state;

    logic                   ready_q, ready_d;
    logic [1:0]             status_q, status_d;
    logic [BUS_WIDTH-1:0]   read_data_q, read_data_d;
    logic [ARRAY_SIZE-1:0]  bf_valid_q, bf_valid_d;
    logic [DATA_WIDTH-1:0]  read_mask_q, read_mask_d;
    logic [DATA_WIDTH-1:0]  write_mask_q, write_mask_d;
    logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]  stage_data_q, stage_data_d;
    logic [DATA_WIDTH-1:0]  stage_mask_q, stage_mask_d;
    logic [ENTRY_WIDTH-1:0] stage_tag_q, stage_tag_d;
    logic                   stage_valid_q, stage_valid_d;
`ifdef RGGEN_WIDE_REGISTER_SNAPSHOT_EN
    logic [DATA_WIDTH-1:0]  snap_data_q, snap_data_d;
    logic [ENTRY_WIDTH-1:0] snap_tag_q, snap_tag_d;
    logic                   snap_valid_q, snap_valid_d;
`endif

    int                     shift;
    logic [BUS_WIDTH-1:0]   bus_mask;
    logic [BUS_WIDTH-1:0]   live_slice;
    logic [DATA_WIDTH-1:0]  beat_mask, beat_data, slice_mask;
    logic [DATA_WIDTH-1:0]  live_data, base_data, base_mask;
    logic [ARRAY_SIZE-1:0]  entry_select;
    logic                   unused_non_posted;

    assign unused_non_posted = i_register_access[ACCESS_NON_POSTED_BIT];

    rggen_wide_register_decoder #(
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .OFFSET_ADDRESS (OFFSET_ADDRESS),
        .BUS_WIDTH      (BUS_WIDTH),
        .BEATS          (BEATS),
        .ARRAY_SIZE     (ARRAY_SIZE),
        .ENTRY_WIDTH    (ENTRY_WIDTH),
        .BEAT_WIDTH     (BEAT_WIDTH)
    ) u_decoder (
        .address (i_register_address),
        .active  (active),
        .entry   (entry),
        .beat    (beat)
    );

    assign accept               = o_register_active && i_register_valid;
    assign o_register_active    = active && (state == STATE_IDLE);
    assign o_register_status    = status_q;
    assign o_register_value     = i_bit_field_value;
    assign o_bit_field_read_mask  = read_mask_q;
    assign o_bit_field_write_mask = write_mask_q;
    assign o_bit_field_write_data = write_data_q;
    // A reset landing in the response cycle drops that response outright.
    assign o_register_ready     = ready_q && !i_rst;
    assign o_register_read_data = i_rst ? '0 : read_data_q;
    assign o_bit_field_valid    = i_rst ? '0 : bf_valid_q;

    always_comb begin
        shift    = int'(beat) * BUS_WIDTH;
        bus_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            bus_mask[8*i +: 8] = {8{i_register_strobe[i]}};
        end
        beat_mask  = DATA_WIDTH'(bus_mask) << shift;
        beat_data  = DATA_WIDTH'(i_register_write_data & bus_mask) << shift;
        slice_mask = DATA_WIDTH'({BUS_WIDTH{1'b1}}) << shift;
        live_data  = '0;
        if (int'(entry) < ARRAY_SIZE) begin
            live_data = i_bit_field_read_data[int'(entry)*DATA_WIDTH +: DATA_WIDTH];
        end
        live_slice   = BUS_WIDTH'(live_data >> shift);
        entry_select = ARRAY_SIZE'(1) << entry;
        // Staged slices only count toward the entry they were written for.
        base_data = '0;
        base_mask = '0;
        if (stage_valid_q && (stage_tag_q == entry)) begin
            base_data = stage_data_q;
            base_mask = stage_mask_q;
        end
    end

    always_comb begin
        next_state    = state;
        ready_d       = 1'b0;
        status_d      = STATUS_OKAY;
        read_data_d   = '0;
        bf_valid_d    = '0;
        read_mask_d   = '0;
        write_mask_d  = '0;
        write_data_d  = '0;
        stage_data_d  = stage_data_q;
        stage_mask_d  = stage_mask_q;
        stage_tag_d   = stage_tag_q;
        stage_valid_d = stage_valid_q;
`ifdef RGGEN_WIDE_REGISTER_SNAPSHOT_EN
        snap_data_d   = snap_data_q;
        snap_tag_d    = snap_tag_q;
        snap_valid_d  = snap_valid_q;
`endif
        case (state)
            STATE_IDLE: begin
                if (accept) begin
                    next_state = STATE_RESP;
                    ready_d    = 1'b1;
                    if (i_register_access[ACCESS_WRITE_BIT]) begin
                        if (!WRITABLE) begin
                            status_d = STATUS_SLAVE_ERROR;
                        end else if (beat != LAST_BEAT) begin
                            stage_data_d  = (base_data & ~beat_mask) | beat_data;
                            stage_mask_d  = base_mask | beat_mask;
                            stage_tag_d   = entry;
                            stage_valid_d = 1'b1;
                        end else begin
                            write_data_d  = (base_data & ~beat_mask) | beat_data;
                            write_mask_d  = base_mask | beat_mask;
                            bf_valid_d    = entry_select;
                            stage_data_d  = '0;
                            stage_mask_d  = '0;
                            stage_valid_d = 1'b0;
                        end
                    end else if (!READABLE) begin
                        status_d = STATUS_SLAVE_ERROR;
                    end else begin
`ifdef RGGEN_WIDE_REGISTER_SNAPSHOT_EN
                        // Beat 0 pulses the whole entry once; later beats replay the snapshot.
                        if (beat == '0) begin
                            snap_data_d  = live_data;
                            snap_tag_d   = entry;
                            snap_valid_d = 1'b1;
                            read_data_d  = live_slice;
                            bf_valid_d   = entry_select;
                            read_mask_d  = '1;
                        end else if (snap_valid_q && (snap_tag_q == entry)) begin
                            read_data_d  = BUS_WIDTH'(snap_data_q >> shift);
                        end else begin
                            read_data_d  = live_slice;
                            bf_valid_d   = entry_select;
                            read_mask_d  = slice_mask;
                        end
`else
                        read_data_d = live_slice;
                        bf_valid_d  = entry_select;
                        read_mask_d = slice_mask;
`endif
                    end
                end
            end
            STATE_RESP: next_state = STATE_IDLE;
            default:    next_state = STATE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= STATE_IDLE;
            ready_q       <= 1'b0;
            status_q      <= STATUS_OKAY;
            read_data_q   <= '0;
            bf_valid_q    <= '0;
            read_mask_q   <= '0;
            write_mask_q  <= '0;
            write_data_q  <= '0;
            stage_data_q  <= '0;
            stage_mask_q  <= '0;
            stage_tag_q   <= '0;
            stage_valid_q <= 1'b0;
`ifdef RGGEN_WIDE_REGISTER_SNAPSHOT_EN
            snap_data_q   <= '0;
            snap_tag_q    <= '0;
            snap_valid_q  <= 1'b0;
`endif
        end else begin
            state         <= next_state;
            ready_q       <= ready_d;
            status_q      <= status_d;
            read_data_q   <= read_data_d;
            bf_valid_q    <= bf_valid_d;
            read_mask_q   <= read_mask_d;
            write_mask_q  <= write_mask_d;
            write_data_q  <= write_data_d;
            stage_data_q  <= stage_data_d;
            stage_mask_q  <= stage_mask_d;
            stage_tag_q   <= stage_tag_d;
            stage_valid_q <= stage_valid_d;
`ifdef RGGEN_WIDE_REGISTER_SNAPSHOT_EN
            snap_data_q   <= snap_data_d;
            snap_tag_q    <= snap_tag_d;
            snap_valid_q  <= snap_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_rggen_wide_register_array.sv
// Scoreboard bench for rggen_wide_register_array: a byte-level reference model
// predicts each response, a negedge monitor pops and compares.
module tb_rggen_wide_register_array;

    localparam int BEATS = 2;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] read_data;
        logic [3:0]  bf_valid;
        logic [63:0] read_mask;
        logic [63:0] write_mask;
        logic [63:0] write_data;
    } resp_t;

    logic         clk;
    logic         rst;
    logic         valid;
    logic         ro_valid;
    logic [1:0]   access;
    logic [7:0]   address;
    logic [31:0]  wdata;
    logic [3:0]   strobe;
    logic         active, ready;
    logic [1:0]   status;
    logic [31:0]  rdata;
    logic [255:0] reg_value;
    logic [3:0]   bf_valid;
    logic [63:0]  rmask, wmask, wdata_out;
    logic         ro_active, ro_ready;
    logic [1:0]   ro_status;
    logic [31:0]  ro_rdata;
    logic [255:0] ro_value;
    logic [3:0]   ro_bf_valid;
    logic [63:0]  ro_rmask, ro_wmask, ro_wdata_out;
    logic [63:0]  live [4];
    logic [255:0] bf_rdata;
    logic [255:0] bf_value;

    resp_t        exp_q [$];
    int           vectors;
    int           miscompares;

    logic [63:0]  stage_data, stage_mask, snap_data;
    bit           stage_ok, snap_ok;
    int           stage_entry, snap_entry;

    assign bf_rdata = {live[3], live[2], live[1], live[0]};

    rggen_wide_register_array dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_register_valid       (valid),
        .i_register_access      (access),
        .i_register_address     (address),
        .i_register_write_data  (wdata),
        .i_register_strobe      (strobe),
        .o_register_active      (active),
        .o_register_ready       (ready),
        .o_register_status      (status),
        .o_register_read_data   (rdata),
        .o_register_value       (reg_value),
        .o_bit_field_valid      (bf_valid),
        .o_bit_field_read_mask  (rmask),
        .o_bit_field_write_mask (wmask),
        .o_bit_field_write_data (wdata_out),
        .i_bit_field_read_data  (bf_rdata),
        .i_bit_field_value      (bf_value)
    );

    rggen_wide_register_array #(.WRITABLE(1'b0)) dut_ro (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_register_valid       (ro_valid),
        .i_register_access      (access),
        .i_register_address     (address),
        .i_register_write_data  (wdata),
        .i_register_strobe      (strobe),
        .o_register_active      (ro_active),
        .o_register_ready       (ro_ready),
        .o_register_status      (ro_status),
        .o_register_read_data   (ro_rdata),
        .o_register_value       (ro_value),
        .o_bit_field_valid      (ro_bf_valid),
        .o_bit_field_read_mask  (ro_rmask),
        .o_bit_field_write_mask (ro_wmask),
        .o_bit_field_write_data (ro_wdata_out),
        .i_bit_field_read_data  (bf_rdata),
        .i_bit_field_value      (bf_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic resetModel();
        stage_ok = 0; stage_data = '0; stage_mask = '0; stage_entry = 0;
        snap_ok = 0; snap_data = '0; snap_entry = 0;
    endtask

    // Reference model: byte-granular staging and snapshot bookkeeping per access.
    task automatic modelAccess(input bit is_write, input int entry, input int beat,
                               input logic [31:0] data, input logic [3:0] strb, output resp_t e);
        logic [63:0] d, m, row;
        e.status = 2'b00; e.read_data = '0; e.bf_valid = '0;
        e.read_mask = '0; e.write_mask = '0; e.write_data = '0;
        if (is_write) begin
            if (stage_ok && stage_entry == entry) begin d = stage_data; m = stage_mask; end
            else begin d = '0; m = '0; end
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    d[(beat*4+b)*8 +: 8] = data[b*8 +: 8];
                    m[(beat*4+b)*8 +: 8] = 8'hFF;
                end
            end
            if (beat < BEATS - 1) begin
                stage_data = d; stage_mask = m; stage_entry = entry; stage_ok = 1;
            end else begin
                e.bf_valid = 4'(1 << entry); e.write_data = d; e.write_mask = m;
                stage_ok = 0; stage_data = '0; stage_mask = '0;
            end
        end else begin
            row = live[entry];
`ifdef RGGEN_WIDE_REGISTER_SNAPSHOT_EN
            if (beat == 0) begin
                snap_ok = 1; snap_entry = entry; snap_data = row;
                e.read_data = row[31:0]; e.bf_valid = 4'(1 << entry); e.read_mask = '1;
            end else if (snap_ok && snap_entry == entry) begin
                e.read_data = snap_data[beat*32 +: 32];
            end else begin
                e.read_data = row[beat*32 +: 32]; e.bf_valid = 4'(1 << entry);
                e.read_mask = 64'hFFFF_FFFF << (beat*32);
            end
`else
            e.read_data = row[beat*32 +: 32]; e.bf_valid = 4'(1 << entry);
            e.read_mask = 64'hFFFF_FFFF << (beat*32);
`endif
        end
    endtask

    // Called just after a clock edge; returns just after the edge closing the response cycle.
    task automatic applyStimulus(input bit is_write, input int entry, input int beat,
                                 input logic [31:0] data, input logic [3:0] strb, input bit drop);
        resp_t e;
        valid = 1'b1; access = {1'b1, is_write};
        address = 8'((entry*BEATS + beat) * 4); wdata = data; strobe = strb;
        #1 checkOutput("active", active, 1);
        modelAccess(is_write, entry, beat, data, strb, e);
        if (!drop) exp_q.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0;
        if (drop) begin rst = 1'b1; resetModel(); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ready", ready, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("status", status, e.status);
                checkOutput("read_data", rdata, e.read_data);
                checkOutput("bf_valid", bf_valid, e.bf_valid);
                checkOutput("read_mask", rmask, e.read_mask);
                checkOutput("write_mask", wmask, e.write_mask);
                checkOutput("write_data", wdata_out, e.write_data);
            end
        end else begin
            checkOutput("idle_read_data", rdata, 0);
            checkOutput("idle_bf_valid", bf_valid, 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; valid = 1'b0; ro_valid = 1'b0;
        access = '0; address = '0; wdata = '0; strobe = '0;
        for (int i = 0; i < 4; i++) live[i] = '0;
        bf_value = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        resetModel();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_status", status, 0);
        checkOutput("reset_write_data", wdata_out, 0);
        checkOutput("reset_write_mask", wmask, 0);
        checkOutput("reset_read_mask", rmask, 0);
        checkOutput("register_value", reg_value, bf_value);

        $display("[TB] wide write commit to entry 2");
        applyStimulus(1, 2, 0, 32'hAAAA_5555, 4'hF, 0);
        applyStimulus(1, 2, 1, 32'h1234_5678, 4'hF, 0);

        $display("[TB] staging discarded by write to a different entry");
        applyStimulus(1, 1, 0, 32'hCAFE_F00D, 4'hF, 0);
        applyStimulus(1, 3, 0, 32'h0000_0001, 4'hF, 0);
        applyStimulus(1, 3, 1, 32'h0000_0002, 4'hF, 0);

        $display("[TB] read snapshot versus live data");
        live[0] = 64'h1111_2222_3333_4444;
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0);
        live[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(0, 0, 1, 32'h0, 4'h0, 0);

        $display("[TB] partial strobe staging");
        applyStimulus(1, 1, 0, 32'hDEAD_BEEF, 4'h3, 0);
        applyStimulus(1, 1, 1, 32'h0BAD_F00D, 4'hF, 0);

        $display("[TB] out-of-range address");
        valid = 1'b1; access = 2'b10; address = 8'h20;
        #1 checkOutput("inactive_entry4", active, 0);
        @(posedge clk); #1;
        address = 8'hFC;
        #1 checkOutput("inactive_top", active, 0);
        @(posedge clk); #1;
        valid = 1'b0;

        $display("[TB] read-only instance rejects writes");
        ro_valid = 1'b1; access = 2'b11; address = 8'h04; wdata = 32'h5A5A_5A5A; strobe = 4'hF;
        #1 checkOutput("ro_active", ro_active, 1);
        @(posedge clk); #1;
        ro_valid = 1'b0;
        checkOutput("ro_ready", ro_ready, 1);
        checkOutput("ro_status", ro_status, 2'b10);
        checkOutput("ro_bf_valid", ro_bf_valid, 0);
        checkOutput("ro_read_data", ro_rdata, 0);
        @(posedge clk); #1;

        $display("[TB] reset during response");
        applyStimulus(1, 2, 0, 32'h0000_0055, 4'hF, 0);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 1);
        checkOutput("post_reset_status", status, 0);
        checkOutput("post_reset_write_data", wdata_out, 0);
        checkOutput("post_reset_write_mask", wmask, 0);
        checkOutput("post_reset_read_mask", rmask, 0);
        live[0] = 64'h7654_3210_0123_4567;
        applyStimulus(0, 0, 1, 32'h0, 4'h0, 0);
        applyStimulus(1, 2, 1, 32'h9999_8888, 4'hF, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) live[$urandom_range(0, 3)] = {$urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                          $urandom, 4'($urandom_range(0, 15)), 0);
        end

        repeat (2) @(posedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rggen_wide_register_array.md
# rggen_wide_register_array

Parametrised register slice for rggen-generated register maps. It supports register arrays (`ARRAY_SIZE` entries) and registers wider than the bus (`DATA_WIDTH` = `BEATS` × `BUS_WIDTH`). Wide writes are staged beat by beat and committed atomically. Wide reads are snapshotted on the first beat. The block sits between the rggen bus adapter and the per-entry bit-field logic, and replaces the single-register slice wherever arrays or wide registers are required.

## Interface
- `READABLE`, default 1'b1: reads permitted; otherwise a read returns SLAVE_ERROR.
- `WRITABLE`, default 1'b1: writes permitted; otherwise a write returns SLAVE_ERROR with no effect.
- `ADDRESS_WIDTH`, default 8: byte-address width.
- `OFFSET_ADDRESS`, default 0: byte address of entry 0, beat 0.
- `BUS_WIDTH`, default 32: bus data width.
- `DATA_WIDTH`, default 64: register width; must equal `BEATS` × `BUS_WIDTH`, with `BEATS` a power of 2 (1 to 8).
- `ARRAY_SIZE`, default 4: number of entries (1 to 64).
- `i_clk` input 1: clock.
- `i_rst` input 1: reset. **One clock; reset is synchronous and active-high.**
- `i_register_valid` input 1: request; held by the master until `o_register_ready`.
- `i_register_access` input 2: bit 0 = write, bit 1 = non-posted.
- `i_register_address` input `ADDRESS_WIDTH`: byte address.
- `i_register_write_data` input `BUS_WIDTH`: write data.
- `i_register_strobe` input `BUS_WIDTH/8`: byte enables.
- `o_register_active` output 1: combinational address hit.
- `o_register_ready` output 1: one-cycle completion pulse.
- `o_register_status` output 2: 2'b00 OKAY, 2'b10 SLAVE_ERROR; valid while ready.
- `o_register_read_data` output `BUS_WIDTH`: valid while ready; 0 otherwise.
- `o_register_value` output `ARRAY_SIZE*DATA_WIDTH`: `i_bit_field_value` passed through.
- `o_bit_field_valid` output `ARRAY_SIZE`: per-entry access pulse.
- `o_bit_field_read_mask`, `o_bit_field_write_mask`, `o_bit_field_write_data` output `DATA_WIDTH`, each: shared across entries; qualified by `o_bit_field_valid`.
- `i_bit_field_read_data`, `i_bit_field_value` input `ARRAY_SIZE*DATA_WIDTH`, each: per-entry field data.

## Operation
- **Decode:** word index w = (address − `OFFSET_ADDRESS`) >> log2(`BUS_WIDTH/8`).
  - entry = w / `BEATS`; beat = w % `BEATS`.
  - Active when address ≥ `OFFSET_ADDRESS` and entry < `ARRAY_SIZE`.
- **FSM:** states IDLE and RESP.
  - IDLE→RESP on valid & active (the accept cycle).
  - RESP→IDLE unconditionally after one cycle.
  - `o_register_active` is masked low in RESP.
- **Write, beat < `BEATS`−1:**
  - Merge data into staging buffer slice `beat` under the byte strobes.
  - OR the strobe-expanded mask into the staging mask.
  - Set staging tag = entry, tag valid.
  - No `o_bit_field_valid`.
- **Write, beat = `BEATS`−1 (commit):**
  - Write data/mask = staging contents plus the current beat. Staged slices are used only if tag valid and tag == entry.
  - Pulse `o_bit_field_valid[entry]`.
  - Clear staging (data, mask, tag valid).
- **Staging conflicts:**
  - A non-final write to a different entry discards the prior staging before merging.
  - Writes never disturb the read snapshot.
- **Read, beat 0:**
  - Capture `i_bit_field_read_data[entry]` into the snapshot; set snapshot tag = entry, valid.
  - Return slice 0.
  - Pulse `o_bit_field_valid[entry]` with `o_bit_field_read_mask` all ones (side-effect fields act once).
- **Read, beat > 0:**
  - Snapshot valid and tag matches: return the snapshot slice; no bit-field pulse.
  - Otherwise: return the live slice and pulse valid, read mask limited to that slice.
- **Permission errors:** SLAVE_ERROR, read data 0, no pulses, no staging/snapshot change.

## Timing
- Accept in cycle N. In N+1: `o_register_ready`=1, status, read data, `o_bit_field_valid` and masks, all registered. Latency is 1 cycle.
- Read data is sampled from `i_bit_field_read_data` in cycle N.
- Back-to-back: the next accept is possible in N+2.
- Reset values: state IDLE, ready 0, status 2'b00, read data 0, `o_bit_field_valid` 0, all masks and data 0, staging cleared, snapshot invalid.
- Reset asserted during RESP: the response is dropped (no ready). The master must re-issue.
- `BEATS`=1: every write commits immediately; the snapshot is unused.

## Configuration
- `RGGEN_WIDE_REGISTER_SNAPSHOT_EN` defined: read snapshot as above.
- Not defined: no snapshot storage. Every read returns the live slice, with a per-slice read-mask pulse.

## Structure
- Shared package `rggen_rtl_pkg` holds:
  - access bit positions;
  - status encodings (OKAY/SLAVE_ERROR);
  - the FSM state encoding;
  - the `clog2` function.
- Sub-module `rggen_wide_register_decoder`: combinational address→{active, entry, beat}.

## Test plan
- Defaults. Write entry 2, beat 0 = 0xAAAA5555 (strobe 0xF), then beat 1 = 0x12345678 → a single `o_bit_field_valid[2]` pulse on the second access, write_data 0x12345678AAAA5555, mask all ones.
- Write entry 1, beat 0; then entry 3, beat 0 (0x1); then entry 3, beat 1 (0x2) → commit to entry 3 = 0x0000000200000001. Entry 1 gets no pulse.
- Entry 0 read data 0x1111_2222_3333_4444. Read beat 0 → 0x33334444. Change input to 0xFFFF…, read beat 1 → 0x11112222 (macro defined) or 0xFFFFFFFF (macro undefined).
- `WRITABLE`=0: write → status 2'b10 in N+1, no bit-field pulse. Address beyond entry 3 → `o_register_active`=0.
- Assert `i_rst` in the RESP cycle → no ready. After release, all outputs are 0 and a beat-1 read returns live data.
- Strobe 0x3 on a beat-0 write of 0xDEADBEEF, then commit → write_mask[31:0] = 0x0000FFFF, data[15:0] = 0xBEEF.
